// File: rtl/conv_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module   : conv_stream_engine
//  Purpose  : Streaming 3x3 convolution over LANES 8-bit pixels per beat.
//             Two line-buffer RAMs hold the previous two rows. A sliding
//             3-row by (LANES+2)-pixel window feeds a six-stage
//             multiply/add/shift/clamp pipeline. All state moves on one
//             global advance, so output backpressure stalls the whole engine.
//  Ports    : clk, rst_n              - clock, async active-low reset
//             cfg_we/cfg_addr/cfg_data - kernel k0..k8 (0-8), shift (9),
//                                       edge mode (10); writes only while idle
//             img_width/img_height    - frame size, sampled on start
//             start/busy/done         - frame control and status
//             in_valid/in_ready/in_data     - input pixel stream
//             out_valid/out_ready/out_data/out_last - output pixel stream
//  Revision : 1.0 - initial release
// ============================================================================
module conv_stream_engine #(
   parameter int LANES      = 64,
   parameter int MAX_WIDTH  = 4096,
   parameter int MAX_HEIGHT = 4096
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_we,
   input  logic [3:0]                  cfg_addr,
   input  logic [7:0]                  cfg_data,
   input  logic [$clog2(MAX_WIDTH):0]  img_width,
   input  logic [$clog2(MAX_HEIGHT):0] img_height,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [8*LANES-1:0]          in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [8*LANES-1:0]          out_data,
   output logic                        out_last
);
   localparam int DW    = 8 * LANES;
   localparam int LL    = $clog2(LANES);
   localparam int WW    = $clog2(MAX_WIDTH) + 1;
   localparam int HW    = $clog2(MAX_HEIGHT) + 1;
   localparam int DEPTH = MAX_WIDTH / LANES;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW    = WW - LL;
   localparam int CW    = $clog2(DEPTH * (MAX_HEIGHT + 1) + 2) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            state, state_nx;
   logic              adv, entry, emit, done_set;

   // configuration
   logic signed [7:0] coef [9];
   logic [3:0]        shift;
   logic              mode;

   // frame geometry and position counters
   logic [BW-1:0]     beats;
   logic [HW-1:0]     height;
   logic [CW-1:0]     n_beats, j_cnt;
   logic [BW-1:0]     in_col, out_col;
   logic [HW-1:0]     out_row;

   // line buffers and column history
   logic [DW-1:0]     lb_a [DEPTH];
   logic [DW-1:0]     lb_b [DEPTH];
   logic [DW-1:0]     rd_a, rd_b;
   logic [DW-1:0]     cur_row [3];
   logic [DW-1:0]     hist1 [3];
   logic [7:0]        hist2_last [3];

   // pipeline
   logic [4:0]        pv, pl;
   logic [7:0]        s1_px [3][LANES+2];
   logic              s1_left, s1_right, s1_top, s1_bot;
   logic [7:0]        hpad [3][LANES+2];
   logic [7:0]        win_pad [3][LANES+2];
   logic [7:0]        s2_px [3][LANES+2];
   logic signed [19:0] s3_prod [LANES][9];
   logic signed [19:0] s4_sum [LANES][5];
   logic signed [19:0] s5_sum [LANES];
   logic signed [19:0] shifted [LANES];
   logic [DW-1:0]     out_next;

   logic              unused_lsbs;
   assign unused_lsbs = ^img_width[LL-1:0];

   assign busy = (state != S_IDLE);
   // Output beat k is formed once beat k+B+1 enters the window.
   assign emit = (j_cnt > CW'(beats));

   // ------------------------------------------------------------------ FSM
   always_comb begin
      adv      = !out_valid || out_ready;
      in_ready = adv && (state == S_RUN);
      entry    = 1'b0;
      done_set = 1'b0;
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_RUN;
         end
         S_RUN: begin
            entry = in_valid && in_ready;
            if (entry && (j_cnt == n_beats - CW'(1))) state_nx = S_FLUSH;
         end
         S_FLUSH: begin
            // zero beats are injected on every advance, no handshake
            entry = adv;
            if (adv && (j_cnt == n_beats + CW'(beats))) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            // stay busy through the done cycle so a coincident start is ignored
            if (done) state_nx = S_IDLE;
            else if (out_valid && out_ready && out_last) done_set = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // --------------------------------------------------------- configuration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) coef[i] <= (i == 4) ? 8'sd1 : 8'sd0;
         shift <= '0;
         mode  <= 1'b0;
      end else if (cfg_we && !busy) begin
         if (cfg_addr < 4'd9)        coef[cfg_addr] <= cfg_data;
         else if (cfg_addr == 4'd9)  shift <= cfg_data[3:0];
         else if (cfg_addr == 4'd10) mode  <= cfg_data[0];
      end
   end

   // ------------------------------------------------------- line buffers
   // Asynchronous read gives read-before-write at the same column.
   assign rd_a = lb_a[in_col[AW-1:0]];
   assign rd_b = lb_b[in_col[AW-1:0]];

   always_ff @(posedge clk) begin
      if (entry) begin
         lb_a[in_col[AW-1:0]] <= cur_row[2];
         lb_b[in_col[AW-1:0]] <= rd_a;
      end
   end

   always_comb begin
      cur_row[0] = rd_b;                                   // row r-2
      cur_row[1] = rd_a;                                   // row r-1
      cur_row[2] = (state == S_RUN) ? in_data : '0;        // flush beats are zero
   end

   // ------------------------------------------------ control and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         done      <= 1'b0;
         beats     <= '0;
         height    <= '0;
         n_beats   <= '0;
         j_cnt     <= '0;
         in_col    <= '0;
         out_col   <= '0;
         out_row   <= '0;
         pv        <= '0;
         pl        <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         state <= state_nx;
         done  <= done_set;
         if (state == S_IDLE && start) begin
            beats   <= img_width[WW-1:LL];
            height  <= img_height;
            n_beats <= CW'(img_width[WW-1:LL]) * CW'(img_height);
            j_cnt   <= '0;
            in_col  <= '0;
            out_col <= '0;
            out_row <= '0;
         end else if (entry) begin
            j_cnt  <= j_cnt + CW'(1);
            in_col <= (in_col == beats - BW'(1)) ? '0 : in_col + BW'(1);
            if (emit) begin
               if (out_col == beats - BW'(1)) begin
                  out_col <= '0;
                  out_row <= out_row + HW'(1);
               end else begin
                  out_col <= out_col + BW'(1);
               end
            end
         end
         if (adv) begin
            pv        <= {pv[3:0], entry && emit};
            pl        <= {pl[3:0], entry && emit && (out_col == beats - BW'(1))
                                   && (out_row == height - HW'(1))};
            out_valid <= pv[4];
            out_last  <= pl[4];
            out_data  <= out_next;
         end
      end
   end

   // ------------------------------------------------------------ datapath
   // Edge substitution: horizontal first, then vertical from the already
   // fixed middle row, so corners replicate in both axes.
   always_comb begin
      for (int t = 0; t < 3; t++) begin
         for (int p = 0; p < LANES + 2; p++) hpad[t][p] = s1_px[t][p];
         if (s1_left)  hpad[t][0]       = mode ? s1_px[t][1]     : 8'd0;
         if (s1_right) hpad[t][LANES+1] = mode ? s1_px[t][LANES] : 8'd0;
      end
      for (int p = 0; p < LANES + 2; p++) begin
         win_pad[1][p] = hpad[1][p];
         win_pad[0][p] = s1_top ? (mode ? hpad[1][p] : 8'd0) : hpad[0][p];
         win_pad[2][p] = s1_bot ? (mode ? hpad[1][p] : 8'd0) : hpad[2][p];
      end
   end

   always_comb begin
      out_next = '0;
      for (int i = 0; i < LANES; i++) begin
         shifted[i] = s5_sum[i] >>> shift;
         if (shifted[i] < 20'sd0)        out_next[8*i +: 8] = 8'd0;
         else if (shifted[i] > 20'sd255) out_next[8*i +: 8] = 8'd255;
         else                            out_next[8*i +: 8] = shifted[i][7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (entry) begin
         for (int t = 0; t < 3; t++) begin
            hist2_last[t] <= hist1[t][DW-1 -: 8];
            hist1[t]      <= cur_row[t];
         end
      end
      if (adv) begin
         // stage 1: window select (column c-1 edge lane, column c, column c+1 edge lane)
         for (int t = 0; t < 3; t++) begin
            s1_px[t][0] <= hist2_last[t];
            for (int i = 0; i < LANES; i++) s1_px[t][i+1] <= hist1[t][8*i +: 8];
            s1_px[t][LANES+1] <= cur_row[t][7:0];
         end
         s1_left  <= (out_col == '0);
         s1_right <= (out_col == beats - BW'(1));
         s1_top   <= (out_row == '0);
         s1_bot   <= (out_row == height - HW'(1));
         // stage 2: padded window register
         s2_px <= win_pad;
         // stage 3: multiply
         for (int i = 0; i < LANES; i++) begin
            for (int t = 0; t < 3; t++) begin
               for (int d = 0; d < 3; d++) begin
                  s3_prod[i][3*t+d] <= $signed({12'd0, s2_px[t][i+d]})
                                     * $signed({{12{coef[3*t+d][7]}}, coef[3*t+d]});
               end
            end
         end
         // stage 4: add level 1; stage 5: add levels 2-4
         for (int i = 0; i < LANES; i++) begin
            s4_sum[i][0] <= s3_prod[i][0] + s3_prod[i][1];
            s4_sum[i][1] <= s3_prod[i][2] + s3_prod[i][3];
            s4_sum[i][2] <= s3_prod[i][4] + s3_prod[i][5];
            s4_sum[i][3] <= s3_prod[i][6] + s3_prod[i][7];
            s4_sum[i][4] <= s3_prod[i][8];
            s5_sum[i]    <= ((s4_sum[i][0] + s4_sum[i][1]) + (s4_sum[i][2] + s4_sum[i][3]))
                          + s4_sum[i][4];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_stream_engine
//  Purpose  : Self-checking bench for conv_stream_engine. Frames are driven
//             with random handshakes and compared beat by beat against a
//             pixel-level 3x3 convolution model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_stream_engine;
   localparam int LANES   = 64;
   localparam int DW      = 8 * LANES;
   localparam int TIMEOUT = 3000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_we = 1'b0;
   logic [3:0]    cfg_addr = '0;
   logic [7:0]    cfg_data = '0;
   logic [12:0]   img_width = '0;
   logic [12:0]   img_height = '0;
   logic          start = 1'b0;
   logic          busy, done;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;

   int            checks = 0;
   int            errors = 0;

   logic [7:0]    img [0:7][0:255];
   int            kern [9];
   int            shift_v;
   int            mode_v;

   conv_stream_engine dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .img_width  (img_width),
      .img_height (img_height),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pixel-level reference: 3x3 window with padding or coordinate clamping.
   function automatic logic [7:0] ref_px(input int x, input int y, input int w, input int h);
      int acc, xx, yy, p;
      acc = 0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            xx = x + dx;
            yy = y + dy;
            if (mode_v != 0) begin
               xx = (xx < 0) ? 0 : ((xx >= w) ? w - 1 : xx);
               yy = (yy < 0) ? 0 : ((yy >= h) ? h - 1 : yy);
               p  = int'(img[yy][xx]);
            end else if (xx < 0 || xx >= w || yy < 0 || yy >= h) begin
               p = 0;
            end else begin
               p = int'(img[yy][xx]);
            end
            acc += p * kern[(dy + 1) * 3 + dx + 1];
         end
      end
      acc = acc >>> shift_v;
      if (acc < 0)   return 8'd0;
      if (acc > 255) return 8'd255;
      return 8'(acc);
   endfunction

   function automatic logic [DW-1:0] beat_of(input int k, input int nb);
      logic [DW-1:0] v;
      for (int i = 0; i < LANES; i++) v[8*i +: 8] = img[k / nb][(k % nb) * LANES + i];
      return v;
   endfunction

   task automatic cfg_write(input int addr, input int data);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 4'(addr);
      cfg_data = 8'(data);
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   task automatic load_config();
      for (int i = 0; i < 9; i++) cfg_write(i, kern[i]);
      cfg_write(9, shift_v);
      cfg_write(10, mode_v);
   endtask

   task automatic set_identity();
      for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 1 : 0;
      shift_v = 0;
      mode_v  = 0;
   endtask

   task automatic run_frame(input int w, input int h, input int vpct, input int rpct,
                            input bit chk_lat, input bit poke);
      int nb, n, sent, recv, cyc, dones, post, first_in, first_out;
      bit stalled;
      logic [DW-1:0] held;
      logic [DW-1:0] exp_b [$];
      logic [DW-1:0] v;
      nb = w / LANES;
      n  = nb * h;
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < LANES; i++) v[8*i +: 8] = ref_px((k % nb) * LANES + i, k / nb, w, h);
         exp_b.push_back(v);
      end
      img_width  = 13'(w);
      img_height = 13'(h);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sent = 0; recv = 0; cyc = 0; dones = 0; post = 0;
      first_in = -1; first_out = -1; stalled = 1'b0; held = '0;
      while (cyc < TIMEOUT && post < 4) begin
         in_valid  = (sent < n) && (int'($urandom_range(1, 100)) <= vpct);
         in_data   = (sent < n) ? beat_of(sent, nb) : '0;
         out_ready = (int'($urandom_range(1, 100)) <= rpct);
         cfg_we    = poke && (cyc == 3);
         cfg_addr  = 4'd4;
         cfg_data  = 8'd5;
         #1;
         if (stalled) begin
            check("stall_valid", DW'(out_valid), DW'(1));
            check("stall_data", out_data, held);
            stalled = 1'b0;
         end
         if (out_valid && first_out < 0) first_out = cyc;
         if (in_valid && in_ready) begin
            if (first_in < 0) first_in = cyc;
            sent++;
         end
         if (out_valid && out_ready) begin
            if (recv < n) begin
               check($sformatf("data[%0d]", recv), out_data, exp_b[recv]);
               check($sformatf("last[%0d]", recv), DW'(out_last), DW'(recv == n - 1));
            end else begin
               check("extra_beat", DW'(recv), DW'(n - 1));
            end
            recv++;
         end else if (out_valid) begin
            stalled = 1'b1;
            held    = out_data;
         end
         if (done) dones++;
         if (dones > 0) post++;
         @(negedge clk);
         cyc++;
      end
      cfg_we   = 1'b0;
      in_valid = 1'b0;
      check("beats_sent", DW'(sent), DW'(n));
      check("beats_recv", DW'(recv), DW'(n));
      check("done_count", DW'(dones), DW'(1));
      check("busy_after", DW'(busy), DW'(0));
      if (chk_lat) check("latency", DW'(first_out - first_in), DW'(nb + 1 + 6));
   endtask

   initial begin
      // ---- reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_data", out_data, '0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("rst_busy", DW'(busy), DW'(0));
      check("rst_done", DW'(done), DW'(0));
      check("rst_in_ready", DW'(in_ready), DW'(0));
      check("rst_out_valid", DW'(out_valid), DW'(0));
      check("rst_out_last", DW'(out_last), DW'(0));
      check("rst_out_data2", out_data, '0);

      // ---- identity kernel from reset, full throughput
      set_identity();
      for (int y = 0; y < 4; y++) for (int x = 0; x < 128; x++) img[y][x] = 8'((x + y) & 255);
      run_frame(128, 4, 100, 100, 1'b1, 1'b0);

      // ---- box blur, zero padding then replicate
      for (int i = 0; i < 9; i++) kern[i] = 1;
      shift_v = 3;
      mode_v  = 0;
      load_config();
      for (int y = 0; y < 4; y++) for (int x = 0; x < 128; x++) img[y][x] = 8'd80;
      run_frame(128, 4, 100, 100, 1'b0, 1'b0);
      mode_v = 1;
      load_config();
      run_frame(128, 4, 100, 100, 1'b0, 1'b0);

      // ---- Sobel-x step edge and its reverse (negative clamp)
      kern = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
      shift_v = 0;
      mode_v  = 0;
      load_config();
      for (int y = 0; y < 4; y++) for (int x = 0; x < 128; x++) img[y][x] = (x < 64) ? 8'd0 : 8'd200;
      run_frame(128, 4, 100, 100, 1'b0, 1'b0);
      for (int y = 0; y < 4; y++) for (int x = 0; x < 128; x++) img[y][x] = (x < 64) ? 8'd200 : 8'd0;
      run_frame(128, 4, 100, 100, 1'b0, 1'b0);

      // ---- random image, random kernel, random handshakes
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 16)) - 8;
         shift_v = int'($urandom_range(0, 5));
         mode_v  = f;
         load_config();
         for (int y = 0; y < 8; y++) for (int x = 0; x < 256; x++) img[y][x] = 8'($urandom_range(0, 255));
         run_frame(256, 8, 60, 50, 1'b0, 1'b0);
      end

      // ---- config write while busy is ignored
      set_identity();
      load_config();
      for (int y = 0; y < 4; y++) for (int x = 0; x < 128; x++) img[y][x] = 8'($urandom_range(0, 255));
      run_frame(128, 4, 80, 70, 1'b0, 1'b1);

      // ---- reset mid-frame, then a clean frame with the reset kernel
      kern[4] = 3;
      shift_v = 1;
      load_config();
      img_width  = 13'd128;
      img_height = 13'd4;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         in_valid  = 1'b1;
         in_data   = beat_of(c, 2);
         out_ready = 1'b1;
         @(negedge clk);
      end
      check("pre_rst_valid", DW'(out_valid), DW'(1));
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", DW'(busy), DW'(0));
      check("arst_out_valid", DW'(out_valid), DW'(0));
      check("arst_in_ready", DW'(in_ready), DW'(0));
      check("arst_out_last", DW'(out_last), DW'(0));
      check("arst_out_data", out_data, '0);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      set_identity();
      for (int y = 0; y < 4; y++) for (int x = 0; x < 128; x++) img[y][x] = 8'($urandom_range(0, 255));
      run_frame(128, 4, 100, 100, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
